// File: rtl/rs_control_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : rs_control_sequencer_if
// Purpose  : Bundles the decoded-opcode inputs, the Z flag, the datapath
//            register-transfer strobes and the STATE debug code exchanged
//            between the control sequencer and its decoder/datapath.
// Ports    : master - sequencer view (opcode lines and Z in, strobes out)
//            slave  - decoder/datapath view (opcode lines and Z out, strobes in)
// Revision : 1.0 - initial release
// ============================================================================
interface rs_control_sequencer_if #(
    parameter int ST_W = 6
);
    // Decoded opcode lines and status
    logic INOP, ILDAC, ISTAC, IMVAC, IMOVR, IJUMP, IJMPZ, IJPNZ;
    logic IADD, ISUB, IINAC, ICLAC, IAND, IOR, IXOR, INOT;
    logic Z;

    // Register-transfer strobes
    logic AR_LD_PC, AR_LD_DRTR, AR_INC;
    logic PC_INC, PC_LD;
    logic DR_LD_M, DR_LD_AC;
    logic TR_LD, IR_LD, R_LD, AC_LD, Z_LD;
    logic M_WR;
    logic [3:0] ALU_OP;
    logic INSTR_DONE, ILLEGAL;
    logic [ST_W-1:0] STATE;

    modport master (
        input  INOP, ILDAC, ISTAC, IMVAC, IMOVR, IJUMP, IJMPZ, IJPNZ,
        input  IADD, ISUB, IINAC, ICLAC, IAND, IOR, IXOR, INOT, Z,
        output AR_LD_PC, AR_LD_DRTR, AR_INC, PC_INC, PC_LD, DR_LD_M, DR_LD_AC,
        output TR_LD, IR_LD, R_LD, AC_LD, Z_LD, M_WR, ALU_OP,
        output INSTR_DONE, ILLEGAL, STATE
    );

    modport slave (
        output INOP, ILDAC, ISTAC, IMVAC, IMOVR, IJUMP, IJMPZ, IJPNZ,
        output IADD, ISUB, IINAC, ICLAC, IAND, IOR, IXOR, INOT, Z,
        input  AR_LD_PC, AR_LD_DRTR, AR_INC, PC_INC, PC_LD, DR_LD_M, DR_LD_AC,
        input  TR_LD, IR_LD, R_LD, AC_LD, Z_LD, M_WR, ALU_OP,
        input  INSTR_DONE, ILLEGAL, STATE
    );
endinterface
`default_nettype wire

// File: rtl/rs_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rs_control_sequencer
// Purpose  : Control-unit FSM of the relatively simple accumulator CPU.
//            Steps through FETCH1..3, a decode step (DEC) and the execute
//            states of each instruction, driving one cycle of datapath
//            strobes per state. All outputs are Moore functions of the state.
// Ports    : CLK          - rising-edge clock
//            FULL_RESET_N - asynchronous active-low reset
//            bus          - rs_control_sequencer_if.master (opcode lines, Z,
//                           strobes, ALU_OP, INSTR_DONE, ILLEGAL, STATE)
// Revision : 1.0 - initial release
// ============================================================================
module rs_control_sequencer #(
    parameter int ST_W = 6
) (
    input  wire logic               CLK,
    input  wire logic               FULL_RESET_N,
    rs_control_sequencer_if.master  bus
);
    localparam int STATE_W = 6;

    localparam logic [STATE_W-1:0] S_RST    = 6'd0;
    localparam logic [STATE_W-1:0] S_FETCH1 = 6'd1;
    localparam logic [STATE_W-1:0] S_FETCH2 = 6'd2;
    localparam logic [STATE_W-1:0] S_FETCH3 = 6'd3;
    localparam logic [STATE_W-1:0] S_NOP1   = 6'd4;
    localparam logic [STATE_W-1:0] S_LDAC1  = 6'd5;
    localparam logic [STATE_W-1:0] S_LDAC2  = 6'd6;
    localparam logic [STATE_W-1:0] S_LDAC3  = 6'd7;
    localparam logic [STATE_W-1:0] S_LDAC4  = 6'd8;
    localparam logic [STATE_W-1:0] S_LDAC5  = 6'd9;
    localparam logic [STATE_W-1:0] S_STAC1  = 6'd10;
    localparam logic [STATE_W-1:0] S_STAC2  = 6'd11;
    localparam logic [STATE_W-1:0] S_STAC3  = 6'd12;
    localparam logic [STATE_W-1:0] S_STAC4  = 6'd13;
    localparam logic [STATE_W-1:0] S_STAC5  = 6'd14;
    localparam logic [STATE_W-1:0] S_MVAC1  = 6'd15;
    localparam logic [STATE_W-1:0] S_MOVR1  = 6'd16;
    localparam logic [STATE_W-1:0] S_JUMP1  = 6'd17;
    localparam logic [STATE_W-1:0] S_JUMP2  = 6'd18;
    localparam logic [STATE_W-1:0] S_JUMP3  = 6'd19;
    localparam logic [STATE_W-1:0] S_JMPZY1 = 6'd20;
    localparam logic [STATE_W-1:0] S_JMPZY2 = 6'd21;
    localparam logic [STATE_W-1:0] S_JMPZY3 = 6'd22;
    localparam logic [STATE_W-1:0] S_JMPZN1 = 6'd23;
    localparam logic [STATE_W-1:0] S_JMPZN2 = 6'd24;
    localparam logic [STATE_W-1:0] S_JPNZY1 = 6'd25;
    localparam logic [STATE_W-1:0] S_JPNZY2 = 6'd26;
    localparam logic [STATE_W-1:0] S_JPNZY3 = 6'd27;
    localparam logic [STATE_W-1:0] S_JPNZN1 = 6'd28;
    localparam logic [STATE_W-1:0] S_JPNZN2 = 6'd29;
    localparam logic [STATE_W-1:0] S_ADD1   = 6'd30;
    localparam logic [STATE_W-1:0] S_SUB1   = 6'd31;
    localparam logic [STATE_W-1:0] S_INAC1  = 6'd32;
    localparam logic [STATE_W-1:0] S_CLAC1  = 6'd33;
    localparam logic [STATE_W-1:0] S_AND1   = 6'd34;
    localparam logic [STATE_W-1:0] S_OR1    = 6'd35;
    localparam logic [STATE_W-1:0] S_XOR1   = 6'd36;
    localparam logic [STATE_W-1:0] S_NOT1   = 6'd37;
    localparam logic [STATE_W-1:0] S_ILL1   = 6'd38;
    // Decode step: the decoder output becomes valid one cycle after IR_LD.
    localparam logic [STATE_W-1:0] S_DEC    = 6'd39;

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;

    // State register
    always_ff @(posedge CLK or negedge FULL_RESET_N) begin
        if (!FULL_RESET_N) begin
            r_state <= S_RST;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = S_RST;
        case (r_state)
            S_RST:    w_next_state = S_FETCH1;
            S_FETCH1: w_next_state = S_FETCH2;
            S_FETCH2: w_next_state = S_FETCH3;
            S_FETCH3: w_next_state = S_DEC;
            S_DEC: begin
                // Priority chain: lowest opcode wins when several lines are high.
                if      (bus.INOP)  w_next_state = S_NOP1;
                else if (bus.ILDAC) w_next_state = S_LDAC1;
                else if (bus.ISTAC) w_next_state = S_STAC1;
                else if (bus.IMVAC) w_next_state = S_MVAC1;
                else if (bus.IMOVR) w_next_state = S_MOVR1;
                else if (bus.IJUMP) w_next_state = S_JUMP1;
                else if (bus.IJMPZ) w_next_state = bus.Z ? S_JMPZY1 : S_JMPZN1;
                else if (bus.IJPNZ) w_next_state = bus.Z ? S_JPNZN1 : S_JPNZY1;
                else if (bus.IADD)  w_next_state = S_ADD1;
                else if (bus.ISUB)  w_next_state = S_SUB1;
                else if (bus.IINAC) w_next_state = S_INAC1;
                else if (bus.ICLAC) w_next_state = S_CLAC1;
                else if (bus.IAND)  w_next_state = S_AND1;
                else if (bus.IOR)   w_next_state = S_OR1;
                else if (bus.IXOR)  w_next_state = S_XOR1;
                else if (bus.INOT)  w_next_state = S_NOT1;
                else                w_next_state = S_ILL1;
            end
            // Non-final execute states advance to the next consecutive code.
            S_LDAC1, S_LDAC2, S_LDAC3, S_LDAC4,
            S_STAC1, S_STAC2, S_STAC3, S_STAC4,
            S_JUMP1, S_JUMP2, S_JMPZY1, S_JMPZY2, S_JMPZN1,
            S_JPNZY1, S_JPNZY2, S_JPNZN1:
                w_next_state = r_state + 6'd1;
            S_NOP1, S_LDAC5, S_STAC5, S_MVAC1, S_MOVR1,
            S_JUMP3, S_JMPZY3, S_JMPZN2, S_JPNZY3, S_JPNZN2,
            S_ADD1, S_SUB1, S_INAC1, S_CLAC1, S_AND1, S_OR1, S_XOR1, S_NOT1,
            S_ILL1:
                w_next_state = S_FETCH1;
            default:  w_next_state = S_RST;
        endcase
    end

    // Output logic (pure function of the state register)
    always_comb begin
        bus.AR_LD_PC   = 1'b0;
        bus.AR_LD_DRTR = 1'b0;
        bus.AR_INC     = 1'b0;
        bus.PC_INC     = 1'b0;
        bus.PC_LD      = 1'b0;
        bus.DR_LD_M    = 1'b0;
        bus.DR_LD_AC   = 1'b0;
        bus.TR_LD      = 1'b0;
        bus.IR_LD      = 1'b0;
        bus.R_LD       = 1'b0;
        bus.AC_LD      = 1'b0;
        bus.Z_LD       = 1'b0;
        bus.M_WR       = 1'b0;
        bus.ALU_OP     = 4'd0;
        bus.INSTR_DONE = 1'b0;
        bus.ILLEGAL    = 1'b0;
        case (r_state)
            S_FETCH1: bus.AR_LD_PC = 1'b1;
            S_FETCH2: begin bus.DR_LD_M = 1'b1; bus.PC_INC = 1'b1; end
            S_FETCH3: begin bus.IR_LD = 1'b1; bus.AR_LD_PC = 1'b1; end
            S_NOP1:   bus.INSTR_DONE = 1'b1;
            S_LDAC1, S_STAC1: begin
                bus.DR_LD_M = 1'b1; bus.PC_INC = 1'b1; bus.AR_INC = 1'b1;
            end
            S_LDAC2, S_STAC2: begin
                bus.TR_LD = 1'b1; bus.DR_LD_M = 1'b1; bus.PC_INC = 1'b1;
            end
            S_LDAC3, S_STAC3: bus.AR_LD_DRTR = 1'b1;
            S_LDAC4:  bus.DR_LD_M = 1'b1;
            S_LDAC5:  begin bus.AC_LD = 1'b1; bus.INSTR_DONE = 1'b1; end
            S_STAC4:  bus.DR_LD_AC = 1'b1;
            S_STAC5:  begin bus.M_WR = 1'b1; bus.INSTR_DONE = 1'b1; end
            S_MVAC1:  begin bus.R_LD = 1'b1; bus.INSTR_DONE = 1'b1; end
            S_MOVR1:  begin bus.AC_LD = 1'b1; bus.INSTR_DONE = 1'b1; end
            S_JUMP1, S_JMPZY1, S_JPNZY1: begin
                bus.DR_LD_M = 1'b1; bus.AR_INC = 1'b1;
            end
            S_JUMP2, S_JMPZY2, S_JPNZY2: begin
                bus.TR_LD = 1'b1; bus.DR_LD_M = 1'b1;
            end
            S_JUMP3, S_JMPZY3, S_JPNZY3: begin
                bus.PC_LD = 1'b1; bus.INSTR_DONE = 1'b1;
            end
            S_JMPZN1, S_JPNZN1: bus.PC_INC = 1'b1;
            S_JMPZN2, S_JPNZN2: begin bus.PC_INC = 1'b1; bus.INSTR_DONE = 1'b1; end
            S_ADD1, S_SUB1, S_INAC1, S_CLAC1, S_AND1, S_OR1, S_XOR1, S_NOT1: begin
                bus.AC_LD      = 1'b1;
                bus.Z_LD       = 1'b1;
                // ALU states are laid out so that code - 29 is the ALU opcode.
                bus.ALU_OP     = 4'(r_state - 6'd29);
                bus.INSTR_DONE = 1'b1;
            end
            S_ILL1:   begin bus.ILLEGAL = 1'b1; bus.INSTR_DONE = 1'b1; end
            default:  ;
        endcase
    end

    assign bus.STATE = ST_W'(r_state);

endmodule
`default_nettype wire

// File: tb/tb_rs_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_control_sequencer
// Purpose  : Self-checking bench for rs_control_sequencer. Expected
//            (STATE, outputs) pairs are queued per cycle as each instruction
//            is set up and compared one per clock as the FSM runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rs_control_sequencer;
    logic CLK = 1'b0;
    logic FULL_RESET_N = 1'b0;
    always #5 CLK = ~CLK;

    rs_control_sequencer_if #(.ST_W(6)) bus ();

    logic [15:0] ops = '0;
    logic        z   = 1'b0;

    assign bus.INOP  = ops[0];
    assign bus.ILDAC = ops[1];
    assign bus.ISTAC = ops[2];
    assign bus.IMVAC = ops[3];
    assign bus.IMOVR = ops[4];
    assign bus.IJUMP = ops[5];
    assign bus.IJMPZ = ops[6];
    assign bus.IJPNZ = ops[7];
    assign bus.IADD  = ops[8];
    assign bus.ISUB  = ops[9];
    assign bus.IINAC = ops[10];
    assign bus.ICLAC = ops[11];
    assign bus.IAND  = ops[12];
    assign bus.IOR   = ops[13];
    assign bus.IXOR  = ops[14];
    assign bus.INOT  = ops[15];
    assign bus.Z     = z;

    rs_control_sequencer #(.ST_W(6)) dut (
        .CLK          (CLK),
        .FULL_RESET_N (FULL_RESET_N),
        .bus          (bus)
    );

    // Output bit positions in the packed observation vector
    localparam int B_ARPC = 18, B_ARDT = 17, B_ARINC = 16, B_PCINC = 15;
    localparam int B_PCLD = 14, B_DRM = 13, B_DRAC = 12, B_TR = 11, B_IR = 10;
    localparam int B_R = 9, B_AC = 8, B_ZLD = 7, B_MWR = 6, B_DONE = 1, B_ILL = 0;

    logic [18:0] act;
    assign act = {bus.AR_LD_PC, bus.AR_LD_DRTR, bus.AR_INC, bus.PC_INC, bus.PC_LD,
                  bus.DR_LD_M, bus.DR_LD_AC, bus.TR_LD, bus.IR_LD, bus.R_LD,
                  bus.AC_LD, bus.Z_LD, bus.M_WR, bus.ALU_OP, bus.INSTR_DONE,
                  bus.ILLEGAL};

    typedef struct packed {
        logic [5:0]  st;
        logic [18:0] out;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;

    // Strobe table written from the state descriptions.
    function automatic logic [18:0] spec_out(input int s);
        logic [18:0] v;
        v = '0;
        case (s)
            1:  v[B_ARPC] = 1'b1;
            2:  begin v[B_DRM] = 1'b1; v[B_PCINC] = 1'b1; end
            3:  begin v[B_IR] = 1'b1; v[B_ARPC] = 1'b1; end
            4:  v[B_DONE] = 1'b1;
            5, 10: begin v[B_DRM] = 1'b1; v[B_PCINC] = 1'b1; v[B_ARINC] = 1'b1; end
            6, 11: begin v[B_TR] = 1'b1; v[B_DRM] = 1'b1; v[B_PCINC] = 1'b1; end
            7, 12: v[B_ARDT] = 1'b1;
            8:  v[B_DRM] = 1'b1;
            9:  begin v[B_AC] = 1'b1; v[B_DONE] = 1'b1; end
            13: v[B_DRAC] = 1'b1;
            14: begin v[B_MWR] = 1'b1; v[B_DONE] = 1'b1; end
            15: begin v[B_R] = 1'b1; v[B_DONE] = 1'b1; end
            16: begin v[B_AC] = 1'b1; v[B_DONE] = 1'b1; end
            17, 20, 25: begin v[B_DRM] = 1'b1; v[B_ARINC] = 1'b1; end
            18, 21, 26: begin v[B_TR] = 1'b1; v[B_DRM] = 1'b1; end
            19, 22, 27: begin v[B_PCLD] = 1'b1; v[B_DONE] = 1'b1; end
            23, 28: v[B_PCINC] = 1'b1;
            24, 29: begin v[B_PCINC] = 1'b1; v[B_DONE] = 1'b1; end
            30: begin v[B_AC] = 1'b1; v[B_ZLD] = 1'b1; v[5:2] = 4'd1; v[B_DONE] = 1'b1; end
            31: begin v[B_AC] = 1'b1; v[B_ZLD] = 1'b1; v[5:2] = 4'd2; v[B_DONE] = 1'b1; end
            32: begin v[B_AC] = 1'b1; v[B_ZLD] = 1'b1; v[5:2] = 4'd3; v[B_DONE] = 1'b1; end
            33: begin v[B_AC] = 1'b1; v[B_ZLD] = 1'b1; v[5:2] = 4'd4; v[B_DONE] = 1'b1; end
            34: begin v[B_AC] = 1'b1; v[B_ZLD] = 1'b1; v[5:2] = 4'd5; v[B_DONE] = 1'b1; end
            35: begin v[B_AC] = 1'b1; v[B_ZLD] = 1'b1; v[5:2] = 4'd6; v[B_DONE] = 1'b1; end
            36: begin v[B_AC] = 1'b1; v[B_ZLD] = 1'b1; v[5:2] = 4'd7; v[B_DONE] = 1'b1; end
            37: begin v[B_AC] = 1'b1; v[B_ZLD] = 1'b1; v[5:2] = 4'd8; v[B_DONE] = 1'b1; end
            38: begin v[B_ILL] = 1'b1; v[B_DONE] = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic push_state(input int s);
        exp_t e;
        e.st  = 6'(s);
        e.out = spec_out(s);
        sb.push_back(e);
    endtask

    // Queue the full fetch + decode + execute path for one instruction.
    // idx: winning opcode line index (0 = INOP .. 15 = INOT), -1 = illegal.
    task automatic push_path(input int idx, input logic zz);
        push_state(1); push_state(2); push_state(3); push_state(39);
        case (idx)
            0:  push_state(4);
            1:  for (int s = 5; s <= 9; s++) push_state(s);
            2:  for (int s = 10; s <= 14; s++) push_state(s);
            3:  push_state(15);
            4:  push_state(16);
            5:  for (int s = 17; s <= 19; s++) push_state(s);
            6:  if (zz) begin push_state(20); push_state(21); push_state(22); end
                else    begin push_state(23); push_state(24); end
            7:  if (zz) begin push_state(28); push_state(29); end
                else    begin push_state(25); push_state(26); push_state(27); end
            8, 9, 10, 11, 12, 13, 14, 15: push_state(22 + idx);
            default: push_state(38);
        endcase
    endtask

    task automatic set_op(input int idx);
        ops = '0;
        if (idx >= 0) ops[idx] = 1'b1;
    endtask

    task automatic test_reset();
        FULL_RESET_N = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); #1;
            checks++;
            if (bus.STATE !== 6'd0 || act !== 19'd0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d got state=%0d outs=%h want state=0 outs=0",
                         i, bus.STATE, act);
            end
        end
        FULL_RESET_N = 1'b1;
    endtask

    task automatic test_nop();
        exp_t e;
        set_op(0);
        push_path(0, 1'b0);
        while (sb.size() > 0) begin
            @(posedge CLK); #1;
            e = sb.pop_front();
            checks++;
            if (bus.STATE !== e.st || act !== e.out) begin
                failures++;
                $display("FAIL nop got state=%0d outs=%h want state=%0d outs=%h",
                         bus.STATE, act, e.st, e.out);
            end
        end
    endtask

    task automatic test_ldac();
        exp_t e;
        set_op(1);
        push_path(1, 1'b0);
        while (sb.size() > 0) begin
            @(posedge CLK); #1;
            e = sb.pop_front();
            checks++;
            if (bus.STATE !== e.st || act !== e.out) begin
                failures++;
                $display("FAIL ldac got state=%0d outs=%h want state=%0d outs=%h",
                         bus.STATE, act, e.st, e.out);
            end
        end
    endtask

    // Taken, not-taken, and Z flipped right after the path is chosen.
    task automatic test_jmpz();
        exp_t e;
        logic zz;
        for (int pass = 0; pass < 4; pass++) begin
            zz = (pass == 0 || pass == 2);
            z  = zz;
            set_op(6);
            push_path(6, zz);
            while (sb.size() > 0) begin
                @(posedge CLK); #1;
                e = sb.pop_front();
                checks++;
                if (bus.STATE !== e.st || act !== e.out) begin
                    failures++;
                    $display("FAIL jmpz pass=%0d got state=%0d outs=%h want state=%0d outs=%h",
                             pass, bus.STATE, act, e.st, e.out);
                end
                // Passes 2 and 3 flip Z once the FSM sits in DEC+1.
                if (pass >= 2 && e.st >= 6'd20 && e.st <= 6'd24) z = ~zz;
            end
        end
        z = 1'b0;
    endtask

    task automatic test_illegal_priority();
        exp_t e;
        set_op(-1);
        push_path(-1, 1'b0);
        while (sb.size() > 0) begin
            @(posedge CLK); #1;
            e = sb.pop_front();
            checks++;
            if (bus.STATE !== e.st || act !== e.out) begin
                failures++;
                $display("FAIL illegal got state=%0d outs=%h want state=%0d outs=%h",
                         bus.STATE, act, e.st, e.out);
            end
        end
        // Two lines high: the lower opcode (IADD) wins over ISUB.
        ops = '0; ops[8] = 1'b1; ops[9] = 1'b1;
        push_path(8, 1'b0);
        while (sb.size() > 0) begin
            @(posedge CLK); #1;
            e = sb.pop_front();
            checks++;
            if (bus.STATE !== e.st || act !== e.out) begin
                failures++;
                $display("FAIL priority_add_sub got state=%0d outs=%h want state=%0d outs=%h",
                         bus.STATE, act, e.st, e.out);
            end
        end
        // INOP together with INOT: INOP wins.
        ops = '0; ops[0] = 1'b1; ops[15] = 1'b1;
        push_path(0, 1'b0);
        while (sb.size() > 0) begin
            @(posedge CLK); #1;
            e = sb.pop_front();
            checks++;
            if (bus.STATE !== e.st || act !== e.out) begin
                failures++;
                $display("FAIL priority_nop_not got state=%0d outs=%h want state=%0d outs=%h",
                         bus.STATE, act, e.st, e.out);
            end
        end
    endtask

    // Every opcode once, back to back, with a random Z for each.
    task automatic test_back_to_back();
        exp_t e;
        logic zz;
        for (int idx = 0; idx < 16; idx++) begin
            zz = 1'($urandom_range(0, 1));
            z  = zz;
            set_op(idx);
            push_path(idx, zz);
            while (sb.size() > 0) begin
                @(posedge CLK); #1;
                e = sb.pop_front();
                checks++;
                if (bus.STATE !== e.st || act !== e.out) begin
                    failures++;
                    $display("FAIL b2b op=%0d z=%0b got state=%0d outs=%h want state=%0d outs=%h",
                             idx, zz, bus.STATE, act, e.st, e.out);
                end
            end
        end
        z = 1'b0;
    endtask

    task automatic test_reset_in_stac5();
        exp_t e;
        set_op(2);
        push_path(2, 1'b0);
        while (sb.size() > 0) begin
            @(posedge CLK); #1;
            e = sb.pop_front();
            checks++;
            if (bus.STATE !== e.st || act !== e.out) begin
                failures++;
                $display("FAIL stac got state=%0d outs=%h want state=%0d outs=%h",
                         bus.STATE, act, e.st, e.out);
            end
        end
        // Now in STAC5 with M_WR high; assert reset between clock edges.
        #1 FULL_RESET_N = 1'b0;
        #1;
        checks++;
        if (bus.M_WR !== 1'b0 || bus.STATE !== 6'd0) begin
            failures++;
            $display("FAIL async_reset got m_wr=%0b state=%0d want m_wr=0 state=0",
                     bus.M_WR, bus.STATE);
        end
        checks++;
        if (act !== 19'd0) begin
            failures++;
            $display("FAIL async_reset_outs got outs=%h want outs=0", act);
        end
        @(posedge CLK); #1;
        FULL_RESET_N = 1'b1;
        set_op(4);
        push_path(4, 1'b0);
        while (sb.size() > 0) begin
            @(posedge CLK); #1;
            e = sb.pop_front();
            checks++;
            if (bus.STATE !== e.st || act !== e.out) begin
                failures++;
                $display("FAIL restart got state=%0d outs=%h want state=%0d outs=%h",
                         bus.STATE, act, e.st, e.out);
            end
        end
    endtask

    initial begin
        test_reset();
        test_nop();
        test_ldac();
        test_jmpz();
        test_illegal_priority();
        test_back_to_back();
        test_reset_in_stac5();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
